// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use stall, jump/branch flush,
// halt/resume freeze, and cycle/stall/flush counters for debug display.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             ex_mem_read,
  input  logic             jb_taken,
  input  logic             halt_req,
  input  logic             go,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_clr,
  output logic             idex_en,
  output logic             idex_clr,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             memwb_clr,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             go_q;
  logic [CNT_W-1:0] cyc_q, stall_q, flush_q;
  logic             cyc_inc_s, stall_inc_s, flush_inc_s;
  logic             lu_s, go_edge_s;

  // Register 0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign lu_s = ex_mem_read && (ex_dst != {REG_W{1'b0}}) &&
                ((id_use_rs && (id_rs == ex_dst)) || (id_use_rt && (id_rt == ex_dst)));
  assign go_edge_s = go && !go_q;

  // Next-state and buffer control decode; priority halt > flush > stall.
  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_clr    = 1'b0;
    idex_en     = 1'b0;
    idex_clr    = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    memwb_clr   = 1'b0;
    halted      = 1'b0;
    cyc_inc_s   = 1'b0;
    stall_inc_s = 1'b0;
    flush_inc_s = 1'b0;
    if (rst) begin
      ifid_clr  = 1'b1;
      idex_clr  = 1'b1;
      memwb_clr = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          pc_en     = 1'b1;
          ifid_en   = 1'b1;
          idex_en   = 1'b1;
          exmem_en  = 1'b1;
          memwb_en  = 1'b1;
          cyc_inc_s = 1'b1;
          if (halt_req) begin
            // Only WB advances, taking a bubble so the halt request drops out.
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_clr = 1'b1;
            state_d   = ST_HALT;
          end else if (jb_taken) begin
            ifid_clr    = 1'b1;
            idex_clr    = 1'b1;
            flush_inc_s = 1'b1;
          end else if (lu_s) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_clr    = 1'b1;
            stall_inc_s = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_HALT: begin
          halted = 1'b1;
          if (go_edge_s) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_HALT;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // State, go history and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      go_q    <= 1'b0;
      cyc_q   <= CNT_ZERO;
      stall_q <= CNT_ZERO;
      flush_q <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      go_q    <= go;
      if (cnt_clr) begin
        cyc_q   <= CNT_ZERO;
        stall_q <= CNT_ZERO;
        flush_q <= CNT_ZERO;
      end else begin
        if (cyc_inc_s)   cyc_q   <= cyc_q + CNT_ONE;
        if (stall_inc_s) stall_q <= stall_q + CNT_ONE;
        if (flush_inc_s) flush_q <= flush_q + CNT_ONE;
      end
    end
  end

  assign cyc_cnt   = cyc_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a default-width instance plus a
// 4-bit-counter instance sharing the same stimulus for the wrap checks.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst, id_use_rs, id_use_rt, ex_mem_read, jb_taken, halt_req, go, cnt_clr;
  logic [4:0] id_rs, id_rt, ex_dst;

  logic        pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, memwb_en, memwb_clr, halted;
  logic [31:0] cyc_cnt, stall_cnt, flush_cnt;
  logic        pc_en4, ifid_en4, ifid_clr4, idex_en4, idex_clr4, exmem_en4, memwb_en4, memwb_clr4, halted4;
  logic [3:0]  cyc_cnt4, stall_cnt4, flush_cnt4;

  logic [8:0] ctl, ctl4;
  assign ctl  = {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, memwb_en, memwb_clr, halted};
  assign ctl4 = {pc_en4, ifid_en4, ifid_clr4, idex_en4, idex_clr4, exmem_en4, memwb_en4, memwb_clr4, halted4};

  // Expected control vectors: {pc_en,ifid_en,ifid_clr,idex_en,idex_clr,exmem_en,memwb_en,memwb_clr,halted}
  localparam logic [8:0] C_RST  = 9'b001010010;
  localparam logic [8:0] C_IDLE = 9'b110101100;
  localparam logic [8:0] C_LU   = 9'b000111100;
  localparam logic [8:0] C_JB   = 9'b111111100;
  localparam logic [8:0] C_HENT = 9'b000000110;
  localparam logic [8:0] C_HALT = 9'b000000001;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_dst(ex_dst), .ex_mem_read(ex_mem_read), .jb_taken(jb_taken), .halt_req(halt_req), .go(go),
    .cnt_clr(cnt_clr), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_clr(ifid_clr), .idex_en(idex_en),
    .idex_clr(idex_clr), .exmem_en(exmem_en), .memwb_en(memwb_en), .memwb_clr(memwb_clr),
    .halted(halted), .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.CNT_W(4), .REG_W(5)) dut4 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_dst(ex_dst), .ex_mem_read(ex_mem_read), .jb_taken(jb_taken), .halt_req(halt_req), .go(go),
    .cnt_clr(cnt_clr), .pc_en(pc_en4), .ifid_en(ifid_en4), .ifid_clr(ifid_clr4), .idex_en(idex_en4),
    .idex_clr(idex_clr4), .exmem_en(exmem_en4), .memwb_en(memwb_en4), .memwb_clr(memwb_clr4),
    .halted(halted4), .cyc_cnt(cyc_cnt4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_dst = 5'd0; ex_mem_read = 1'b0; jb_taken = 1'b0; halt_req = 1'b0;
    go = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic set_lu();
    ex_mem_read = 1'b1; ex_dst = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #1;
    n_checks++; if (ctl !== C_RST) begin n_errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_RST); end
    tick();
    n_checks++; if ({cyc_cnt, stall_cnt, flush_cnt} !== 96'd0) begin n_errors++; $display("FAIL reset_cnt: got %0d/%0d/%0d expected 0/0/0", cyc_cnt, stall_cnt, flush_cnt); end
    rst = 1'b0;
    #1;
    n_checks++; if (ctl !== C_IDLE) begin n_errors++; $display("FAIL reset_idle: got %b expected %b", ctl, C_IDLE); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_lu();
    #1;
    n_checks++; if (ctl !== C_LU) begin n_errors++; $display("FAIL lu_ctl: got %b expected %b", ctl, C_LU); end
    tick();
    n_checks++; if (stall_cnt !== 32'd1) begin n_errors++; $display("FAIL lu_stall1: got %0d expected 1", stall_cnt); end
    n_checks++; if (ctl !== C_LU) begin n_errors++; $display("FAIL lu_persist: got %b expected %b", ctl, C_LU); end
    tick();
    n_checks++; if (stall_cnt !== 32'd2 || cyc_cnt !== 32'd2) begin n_errors++; $display("FAIL lu_stall2: got %0d/%0d expected 2/2", stall_cnt, cyc_cnt); end
    // Hazard through the rt operand only.
    id_use_rs = 1'b0; id_rs = 5'd3; id_use_rt = 1'b1; id_rt = 5'd8;
    #1;
    n_checks++; if (ctl !== C_LU) begin n_errors++; $display("FAIL lu_rt_ctl: got %b expected %b", ctl, C_LU); end
    tick();
    n_checks++; if (stall_cnt !== 32'd3) begin n_errors++; $display("FAIL lu_rt_stall: got %0d expected 3", stall_cnt); end
  endtask

  task automatic test_no_hazard();
    do_reset();
    set_lu();
    ex_dst = 5'd0; id_rs = 5'd0;
    #1;
    n_checks++; if (ctl !== C_IDLE) begin n_errors++; $display("FAIL zero_dst: got %b expected %b", ctl, C_IDLE); end
    tick();
    set_lu();
    id_use_rs = 1'b0;
    #1;
    n_checks++; if (ctl !== C_IDLE) begin n_errors++; $display("FAIL no_use_rs: got %b expected %b", ctl, C_IDLE); end
    tick();
    set_lu();
    ex_mem_read = 1'b0;
    #1;
    n_checks++; if (ctl !== C_IDLE) begin n_errors++; $display("FAIL no_load: got %b expected %b", ctl, C_IDLE); end
    tick();
    n_checks++; if (stall_cnt !== 32'd0 || cyc_cnt !== 32'd3) begin n_errors++; $display("FAIL nohaz_cnt: got %0d/%0d expected 0/3", stall_cnt, cyc_cnt); end
  endtask

  task automatic test_jb_over_lu();
    do_reset();
    set_lu();
    jb_taken = 1'b1;
    #1;
    n_checks++; if (ctl !== C_JB) begin n_errors++; $display("FAIL jb_ctl: got %b expected %b", ctl, C_JB); end
    tick();
    n_checks++; if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin n_errors++; $display("FAIL jb_cnt: got flush %0d stall %0d expected 1/0", flush_cnt, stall_cnt); end
  endtask

  task automatic test_halt_resume();
    do_reset();
    set_lu();
    halt_req = 1'b1; jb_taken = 1'b1;
    #1;
    n_checks++; if (ctl !== C_HENT) begin n_errors++; $display("FAIL halt_entry: got %b expected %b", ctl, C_HENT); end
    tick();
    n_checks++; if (ctl !== C_HALT) begin n_errors++; $display("FAIL halted: got %b expected %b", ctl, C_HALT); end
    n_checks++; if (flush_cnt !== 32'd0 || cyc_cnt !== 32'd1) begin n_errors++; $display("FAIL halt_cnt: got flush %0d cyc %0d expected 0/1", flush_cnt, cyc_cnt); end
    tick();
    tick();
    n_checks++; if (cyc_cnt !== 32'd1 || ctl !== C_HALT) begin n_errors++; $display("FAIL halt_frozen: got cyc %0d ctl %b expected 1/%b", cyc_cnt, ctl, C_HALT); end
    clear_inputs();
    go = 1'b1;
    #1;
    n_checks++; if (ctl !== C_HALT) begin n_errors++; $display("FAIL go_cycle_frozen: got %b expected %b", ctl, C_HALT); end
    tick();
    n_checks++; if (ctl !== C_IDLE || cyc_cnt !== 32'd1) begin n_errors++; $display("FAIL resume: got ctl %b cyc %0d expected %b/1", ctl, cyc_cnt, C_IDLE); end
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    n_checks++; if (ctl !== C_HALT || cyc_cnt !== 32'd3) begin n_errors++; $display("FAIL rehalt: got ctl %b cyc %0d expected %b/3", ctl, cyc_cnt, C_HALT); end
    tick();
    tick();
    n_checks++; if (ctl !== C_HALT) begin n_errors++; $display("FAIL go_held_no_edge: got %b expected %b", ctl, C_HALT); end
    go = 1'b0;
    tick();
    go = 1'b1;
    tick();
    n_checks++; if (ctl !== C_IDLE || cyc_cnt !== 32'd3) begin n_errors++; $display("FAIL second_resume: got ctl %b cyc %0d expected %b/3", ctl, cyc_cnt, C_IDLE); end
  endtask

  task automatic test_rst_in_halt();
    do_reset();
    jb_taken = 1'b1;
    tick();
    jb_taken = 1'b0;
    set_lu();
    tick();
    clear_inputs();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    n_checks++; if (ctl !== C_HALT || {cyc_cnt, stall_cnt, flush_cnt} !== {32'd3, 32'd1, 32'd1}) begin n_errors++; $display("FAIL pre_rst: got ctl %b cnt %0d/%0d/%0d expected %b 3/1/1", ctl, cyc_cnt, stall_cnt, flush_cnt, C_HALT); end
    rst = 1'b1;
    #1;
    n_checks++; if (ctl !== C_RST) begin n_errors++; $display("FAIL rst_in_halt_ctl: got %b expected %b", ctl, C_RST); end
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (ctl !== C_IDLE || {cyc_cnt, stall_cnt, flush_cnt} !== 96'd0) begin n_errors++; $display("FAIL rst_in_halt_after: got ctl %b cnt %0d/%0d/%0d expected %b 0/0/0", ctl, cyc_cnt, stall_cnt, flush_cnt, C_IDLE); end
  endtask

  task automatic test_wrap_and_clear();
    do_reset();
    for (int i = 0; i < 16; i++) tick();
    n_checks++; if (cyc_cnt4 !== 4'd0 || cyc_cnt !== 32'd16) begin n_errors++; $display("FAIL cyc_wrap: got cnt4 %0d cnt32 %0d expected 0/16", cyc_cnt4, cyc_cnt); end
    n_checks++; if (ctl4 !== C_IDLE) begin n_errors++; $display("FAIL ctl4_idle: got %b expected %b", ctl4, C_IDLE); end
    set_lu();
    tick();
    n_checks++; if (stall_cnt4 !== 4'd1 || cyc_cnt4 !== 4'd1) begin n_errors++; $display("FAIL cnt4_lu: got stall %0d cyc %0d expected 1/1", stall_cnt4, cyc_cnt4); end
    cnt_clr = 1'b1;
    #1;
    n_checks++; if (ctl !== C_LU) begin n_errors++; $display("FAIL clr_lu_ctl: got %b expected %b", ctl, C_LU); end
    tick();
    n_checks++; if (stall_cnt !== 32'd0 || cyc_cnt !== 32'd0 || stall_cnt4 !== 4'd0 || flush_cnt4 !== 4'd0) begin n_errors++; $display("FAIL cnt_clr: got stall %0d cyc %0d stall4 %0d flush4 %0d expected 0/0/0/0", stall_cnt, cyc_cnt, stall_cnt4, flush_cnt4); end
    cnt_clr = 1'b0;
    tick();
    n_checks++; if (stall_cnt !== 32'd1) begin n_errors++; $display("FAIL post_clr_stall: got %0d expected 1", stall_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_jb_over_lu();
    test_halt_resume();
    test_rst_in_halt();
    test_wrap_and_clear();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
